// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and decode.
// Holds instruction, PC, PC+4 and ISA tag per entry; the head entry drives
// the decode-side outputs and a full queue stalls the fetch-stage PC.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ValidF,
  input  logic [31:0]              InstrF,
  input  logic [31:0]              PCF,
  input  logic [31:0]              PCPlus4F,
  input  logic                     ArmF,
  output logic                     StallF,
  input  logic                     StallD,
  input  logic                     FlushD,
  output logic                     ValidD,
  output logic [31:0]              InstrD,
  output logic [31:0]              PCD,
  output logic [31:0]              PCPlus4D,
  output logic                     ArmD,
  output logic [$clog2(DEPTH):0]   CountQ
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   pcMem    [DEPTH];
  logic [31:0]   pc4Mem   [DEPTH];
  logic          armMem   [DEPTH];

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          push;
  logic          pop;

  // Full/valid come only from registered occupancy, so StallF has no path
  // from StallD or FlushD; a same-cycle pop cannot open a slot for a push.
  assign StallF = (CountQ == CW'(DEPTH));
  assign ValidD = (CountQ != '0);
  assign push   = ValidF & ~StallF & ~FlushD;
  assign pop    = ValidD & ~StallD & ~FlushD;

  // Entry storage: written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instrMem[wrPtr] <= InstrF;
      pcMem[wrPtr]    <= PCF;
      pc4Mem[wrPtr]   <= PCPlus4F;
      armMem[wrPtr]   <= ArmF;
    end
  end

  // Pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      CountQ <= '0;
    end else if (FlushD) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      CountQ <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   CountQ <= CountQ + 1'b1;
        2'b01:   CountQ <= CountQ - 1'b1;
        default: CountQ <= CountQ;
      endcase
    end
  end

  // Head entry onto the decode outputs, zeroed while the queue is empty.
  always_comb begin
    InstrD   = '0;
    PCD      = '0;
    PCPlus4D = '0;
    ArmD     = 1'b0;
    if (ValidD) begin
      InstrD   = instrMem[rdPtr];
      PCD      = pcMem[rdPtr];
      PCPlus4D = pc4Mem[rdPtr];
      ArmD     = armMem[rdPtr];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (DEPTH = 4).
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ArmF;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ArmD;
  logic [2:0]  CountQ;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        arm;
  } entry_t;

  entry_t sb[$];
  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .ArmF(ArmF), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ArmD(ArmD), .CountQ(CountQ)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  // One clock: drive inputs, compare outputs against the scoreboard head and
  // expected occupancy, update the scoreboard, then advance to the next negedge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic arm,
                       input logic sD, input logic fD, output logic accepted);
    int cnt;
    entry_t h;
    entry_t e;
    cnt      = sb.size();
    ValidF   = v;
    PCF      = pc;
    PCPlus4F = pc + 32'd4;
    InstrF   = instrOf(pc);
    ArmF     = arm;
    StallD   = sD;
    FlushD   = fD;
    check("CountQ", 32'(CountQ), 32'(cnt));
    check("StallF", 32'(StallF), 32'(cnt == DEPTH));
    check("ValidD", 32'(ValidD), 32'(cnt != 0));
    if (cnt != 0) begin
      h = sb[0];
      check("PCD", PCD, h.pc);
      check("InstrD", InstrD, h.instr);
      check("PCPlus4D", PCPlus4D, h.pc4);
      check("ArmD", 32'(ArmD), 32'(h.arm));
    end else begin
      check("PCDidle", PCD, 32'h0);
      check("InstrDidle", InstrD, 32'h0);
      check("PCPlus4Didle", PCPlus4D, 32'h0);
      check("ArmDidle", 32'(ArmD), 32'h0);
    end
    accepted = v && (cnt != DEPTH) && !fD;
    if (fD) begin
      sb.delete();
    end else begin
      if (cnt != 0 && !sD) void'(sb.pop_front());
      if (accepted) begin
        e.instr = instrOf(pc);
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.arm   = arm;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    logic s;
    int   sent;

    // Reset held two cycles with a valid fetch presented.
    rst = 1'b1; ValidF = 1'b1; PCF = 32'h44; PCPlus4F = 32'h48; InstrF = 32'h1;
    ArmF = 1'b1; StallD = 1'b0; FlushD = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();

    // Streaming: three consecutive pushes with decode consuming.
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, acc);
    check("streamCount", 32'(CountQ), 32'd1);
    cycle(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, acc);
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);

    // Fill with decode stalled; fifth entry is refused.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + 32'(i) * 4, 1'b1, 1'b1, 1'b0, acc);
    check("fullCount", 32'(CountQ), 32'd4);
    check("fullStallF", 32'(StallF), 32'd1);
    cycle(1'b1, 32'h110, 1'b1, 1'b1, 1'b0, acc);
    check("fifthRefused", 32'(acc), 32'd0);

    // Full with pop: pop only, then the re-presented entry is accepted.
    cycle(1'b1, 32'h110, 1'b1, 1'b0, 1'b0, acc);
    check("fullPopNoPush", 32'(acc), 32'd0);
    check("fullPopCount", 32'(CountQ), 32'd3);
    cycle(1'b1, 32'h110, 1'b1, 1'b0, 1'b0, acc);
    check("rePresentAccepted", 32'(acc), 32'd1);

    // Flush at CountQ = 3 drops the same-cycle fetch.
    cycle(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, acc);
    check("flushCount", 32'(CountQ), 32'd0);
    check("flushValidD", 32'(ValidD), 32'd0);
    cycle(1'b1, 32'h204, 1'b0, 1'b1, 1'b0, acc);
    check("postFlushHead", PCD, 32'h204);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);

    // Wrap-around with random decode stalls and alternating ISA tag.
    sent = 0;
    for (int n = 0; n < 200 && (sent < 10 || sb.size() != 0); n++) begin
      s = ($urandom_range(0, 2) == 0);
      cycle(sent < 10, 32'h300 + 32'(sent) * 4, (sent % 2) == 0, s, 1'b0, acc);
      if (acc) sent++;
    end
    check("wrapSent", 32'(sent), 32'd10);
    check("wrapDrained", 32'(sb.size()), 32'd0);

    // Reset mid-operation overrides fetch, stall and flush.
    cycle(1'b1, 32'h400, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h404, 1'b1, 1'b1, 1'b0, acc);
    rst = 1'b1; ValidF = 1'b1; StallD = 1'b0; FlushD = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch stage and the decode stage of the combined ARM/RISC-V pipeline. It buffers up to DEPTH fetched instructions with their PC, PC+4 and ISA tag, so a short decode stall does not immediately back-pressure the PC register. It drives the decode-side valid/instruction signals, exports StallF to the fetch stage, and is cleared by FlushD on any taken branch or PC write.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ValidF  in  1  fetch presents a valid entry this cycle
- InstrF  in  32  instruction word; aligned with PCF by the fetch stage
- PCF  in  32  PC of InstrF
- PCPlus4F  in  32  PCF + 4
- ArmF  in  1  ISA tag: 1 = ARM, 0 = RISC-V
- StallF  out  1  queue cannot accept; drives the fetch-stage PC stall
- StallD  in  1  decode not consuming this cycle
- FlushD  in  1  discard all queued entries
- ValidD  out  1  head entry valid
- InstrD  out  32  head instruction
- PCD  out  32  head PC
- PCPlus4D  out  32  head PC+4
- ArmD  out  1  head ISA tag
- CountQ  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer: write pointer, read pointer, occupancy counter. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- StallF = (CountQ == DEPTH). It is a pure function of registered occupancy, with no combinational path from StallD or FlushD.
- Push = ValidF & !StallF & !FlushD. The entry (InstrF, PCF, PCPlus4F, ArmF) is written at the write pointer, and the write pointer increments.
- Pop = ValidD & !StallD & !FlushD. The read pointer increments.
- Occupancy update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- ValidD = (CountQ != 0).
- InstrD, PCD, PCPlus4D and ArmD show the entry at the read pointer when ValidD = 1. They are forced to 0 when ValidD = 0.
- FlushD has priority over push and pop. On the next edge: pointers = 0, CountQ = 0, and any same-cycle ValidF entry is dropped. Storage contents need not be cleared.
- When full, ValidF is ignored. Fetch holds the entry because StallF is high. A pop in that cycle does not enable a push in the same cycle.
- No bypass path. An entry pushed into an empty queue appears on the D outputs the next cycle.
- rst has priority over FlushD and over all other inputs.

## Timing
- Reset values: CountQ = 0, ValidD = 0, StallF = 0, InstrD/PCD/PCPlus4D = 32'h0, ArmD = 0, pointers = 0.
- Latency from push to head visibility on an empty queue: 1 cycle.
- Throughput: 1 entry per cycle with simultaneous push and pop, at any occupancy below DEPTH.
- After a flush, ValidD is 0 in the following cycle. The first post-flush fetch is visible one cycle after it is pushed.
- Order is strict FIFO, including across pointer wrap-around.
- Reset asserted mid-operation empties the queue on the next edge, regardless of ValidF, StallD or FlushD.

## Test plan
- **Reset:** hold rst 2 cycles with ValidF = 1 → CountQ = 0, ValidD = 0, StallF = 0, all D outputs 0.
- **Streaming:** push PCs 0x0, 0x4, 0x8 on consecutive cycles with StallD = 0.
  - ValidD rises 1 cycle after the first push.
  - PCD sequence is 0x0, 0x4, 0x8 with PCPlus4D = PCD + 4.
  - CountQ stays ≤ 1.
- **Fill:** StallD = 1 while pushing 5 entries (0x100…0x110) with DEPTH = 4.
  - After 4 pushes, StallF = 1 and CountQ = 4.
  - The 5th entry (0x110) is not accepted.
  - After StallD drops, the output order is 0x100, 0x104, 0x108, 0x10C, then 0x110 once it is re-presented.
- **Full with pop:** CountQ = 4, StallD = 0, ValidF = 1 → CountQ = 3 next cycle, no push that cycle; the following cycle accepts the push.
- **Flush:** CountQ = 3, assert FlushD with ValidF = 1 and PCF = 0x200.
  - Next cycle: CountQ = 0, ValidD = 0.
  - A push of 0x204 the cycle after appears alone at the head.
- **Wrap-around:** 10 push/pop pairs with randomized StallD at ArmF alternating 1/0 → strict FIFO order and correct ArmD tag for every entry across pointer wrap; CountQ never exceeds 4.
